vga_clk_en_gen: RTL and testbench
=================================

# vga_clk_en_gen

Multi-channel fractional clock-enable generator for the VGA test design. Derives NUM_CH programmable-rate enable strobes (pixel, memory, audio, etc.) from the single board reference clock using per-channel phase accumulators, so downstream logic stays on one clock domain. Provides a `locked` indication with a settle counter that re-arms on every reconfiguration. It replaces fixed-ratio clock generation for domains that can run as enables of `refclk`.

## Interface
Parameters:
- NUM_CH, 2: number of enable channels (1..8).
- ACC_W, 16: phase accumulator / increment width (8..32).
- LOCK_CYCLES, 256: settle cycles before `locked` asserts (≥2).
- INIT_INC, {16'h4000,16'h8000}: packed NUM_CH×ACC_W reset increments, channel 0 in LSBs.

Ports:
- refclk  in  1  sole clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  increment-write request.
- cfg_ready  out  1  block can accept a write this cycle.
- cfg_ch  in  3  target channel index.
- cfg_inc  in  ACC_W  new increment for cfg_ch.
- cfg_err  out  1  one-cycle pulse: accepted write had cfg_ch ≥ NUM_CH.
- ce  out  NUM_CH  per-channel enable strobes, single-cycle pulses.
- locked  out  1  strobes valid and stable.

## Operation
- Reset values: state SETTLE, settle counter 0, all accumulators 0, inc[i]=INIT_INC[i], ce=0, locked=0, cfg_err=0, cfg_ready=1 after first non-reset edge (0 while rst sampled high).
- Per channel: sum = {1'b0,acc}+{1'b0,inc} (ACC_W+1 bits); acc <= sum[ACC_W-1:0] (wraps); carry = sum[ACC_W].
- ce[i] <= carry[i] when state is LOCKED, else 0. Over any 2^ACC_W consecutive LOCKED cycles channel i produces exactly inc[i] strobes; inc=0 never strobes.
- FSM, two states:
  - SETTLE: counter increments each cycle; on counter==LOCK_CYCLES-1 → LOCKED, counter held.
  - LOCKED: locked=1; stays until accepted cfg write or rst.
- Handshake: write accepted on edge where cfg_valid && cfg_ready. cfg_ready=1 in both states when not in reset; no back-pressure otherwise.
  - cfg_ch < NUM_CH: inc[cfg_ch] <= cfg_inc; state → SETTLE, counter → 0, locked → 0, ce → 0 on that same edge.
  - cfg_ch ≥ NUM_CH: no register change, state untouched, cfg_err pulses high next cycle.
- Simultaneous: valid write accepted on the edge where SETTLE would complete → write wins, remain SETTLE, counter 0.
- rst mid-operation: all registers incl. inc[] return to reset values on that edge; pending cfg_valid ignored.

## Timing
- locked rises on the LOCK_CYCLES-th rising edge after the first edge rst is sampled low (or after a write edge).
- locked falls on the accepting write edge (zero extra latency).
- ce is registered: one cycle from carry to pin. cfg_err one cycle after accept.
- Increment change takes effect on accumulator updates from the edge after acceptance.

## Configuration
- VGA_CLK_EN_GEN_PHASE_ALIGN_EN defined: accumulators are held at 0 throughout SETTLE and start accumulating on the first LOCKED cycle, so all channels restart phase-aligned after every lock. For inc=2^(ACC_W-1), first ce is on the 2nd edge after locked rises, then every 2 cycles.
- Not defined: accumulators run freely in SETTLE (only ce is gated); phase after lock is implementation-arbitrary but rate is exact.

## Test plan
- Reset, defaults, ACC_W=16, LOCK_CYCLES=256 → locked rises exactly 256 edges after rst low; ce[0] 1-in-2 cycles, ce[1] 1-in-4; with ALIGN_EN ce[0] first high 2 edges after locked.
- Write ch1 inc=16'h0001 while locked → locked/ce drop on accept edge, locked returns 256 edges later, ce[1] exactly 1 pulse per 65536 cycles.
- Write ch0 inc=16'h5555 → 21845 ±0 strobes counted over 65536 locked cycles; inc=0 → zero strobes.
- Write cfg_ch=5 with NUM_CH=2 → cfg_err one-cycle pulse, locked stays 1, ce pattern unchanged.
- Write accepted on the edge SETTLE would complete → locked stays 0, full LOCK_CYCLES restart.
- Assert rst for one cycle mid-LOCKED after reprogramming → inc reverts to INIT_INC, ce=0, locked=0, relock timing as first test.

Source files
------------

// File: rtl/vga_clk_en_gen.sv
// vga_clk_en_gen: multi-channel fractional clock-enable generator.
// Each channel adds its increment to a phase accumulator every refclk cycle.
// The accumulator carry-out becomes that channel's single-cycle enable strobe.
// Strobes reach the pins only while the block reports locked.
// A settle counter re-arms on reset and on every accepted increment write.
//
// Optional build macro: VGA_CLK_EN_GEN_PHASE_ALIGN_EN
//   defined   : accumulators are held at zero during SETTLE. All channels
//               restart phase-aligned on the first LOCKED cycle.
//   undefined : accumulators run freely and only the strobes are gated.
//
// state  | meaning
// -------+-----------------------------------------------------------
// SETTLE | counting LOCK_CYCLES after reset/reconfig; ce forced low
// LOCKED | strobes valid; left only on accepted write or rst
module vga_clk_en_gen #(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 16,
  parameter int LOCK_CYCLES = 256,
  parameter logic [NUM_CH*ACC_W-1:0] INIT_INC = {16'h4000, 16'h8000}
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ce,
  output logic              locked
);

  localparam int CNT_W = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  settle_cnt;
  logic [ACC_W-1:0]  acc [NUM_CH];
  logic [ACC_W-1:0]  inc [NUM_CH];
  logic [ACC_W:0]    sum [NUM_CH];
  logic [NUM_CH-1:0] carry;
  logic              accept;
  logic              ch_ok;
  logic              wr_ok;

  assign accept = cfg_valid && cfg_ready;
  assign ch_ok  = ({1'b0, cfg_ch} < 4'(NUM_CH));
  assign wr_ok  = accept && ch_ok;

  // Per-channel phase sum with an explicit carry bit.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i]   = {1'b0, acc[i]} + {1'b0, inc[i]};
      carry[i] = sum[i][ACC_W];
    end
  end

  // Increment registers: reload INIT_INC on reset, take valid writes otherwise.
  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        inc[i] <= INIT_INC[i*ACC_W +: ACC_W];
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_ok && (cfg_ch == 3'(i))) begin
          inc[i] <= cfg_inc;
        end
      end
    end
  end

  // Phase accumulators. A new increment is first used on the edge after the write.
  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
`ifdef VGA_CLK_EN_GEN_PHASE_ALIGN_EN
        if ((state == LOCKED) && !wr_ok) begin
          acc[i] <= sum[i][ACC_W-1:0];
        end else begin
          acc[i] <= '0;
        end
`else
        acc[i] <= sum[i][ACC_W-1:0];
`endif
      end
    end
  end

  // Lock FSM with registered locked/ce/cfg_err/cfg_ready outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state      <= SETTLE;
      settle_cnt <= '0;
      locked     <= 1'b0;
      ce         <= '0;
      cfg_err    <= 1'b0;
      cfg_ready  <= 1'b0;
    end else begin
      cfg_ready <= 1'b1;
      cfg_err   <= accept && !ch_ok;
      if (wr_ok) begin
        // A valid write also wins over a SETTLE completion on the same edge.
        state      <= SETTLE;
        settle_cnt <= '0;
        locked     <= 1'b0;
        ce         <= '0;
      end else begin
        case (state)
          SETTLE: begin
            ce <= '0;
            if (settle_cnt == CNT_LAST) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          LOCKED: begin
            locked <= 1'b1;
            ce     <= carry;
          end
          default: begin
            state      <= SETTLE;
            settle_cnt <= '0;
            locked     <= 1'b0;
            ce         <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_clk_en_gen.sv
// Directed bench for vga_clk_en_gen with default parameters.
// The expected values are hand-computed from the increment arithmetic.
module tb_vga_clk_en_gen;

  logic        refclk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_ch;
  logic [15:0] cfg_inc;
  logic        cfg_err;
  logic [1:0]  ce;
  logic        locked;

  int n_checks = 0;
  int n_fail   = 0;

  vga_clk_en_gen dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_err   (cfg_err),
    .ce        (ce),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts edges until locked is seen high. The count is bounded, and an
  // expired bound shows up as a wrong count.
  task automatic wait_lock(output int n);
    n = 0;
    do begin
      @(posedge refclk);
      #1;
      n++;
    end while (!locked && n < 2000);
  endtask

  // Counts strobes over len edges and records the edge of the first ce[0].
  task automatic count_ce(input int len, output int c0, output int c1, output int first0);
    c0 = 0;
    c1 = 0;
    first0 = 0;
    for (int k = 1; k <= len; k++) begin
      @(posedge refclk);
      #1;
      if (ce[0]) begin
        c0++;
        if (first0 == 0) first0 = k;
      end
      if (ce[1]) c1++;
    end
  endtask

  task automatic do_write(input logic [2:0] ch, input logic [15:0] val);
    @(negedge refclk);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_inc   = val;
    @(posedge refclk);
    #1;
    cfg_valid = 1'b0;
  endtask

  initial begin
    int n, c0, c1, f0;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = 3'd0;
    cfg_inc   = 16'h0;
    repeat (3) @(posedge refclk);
    #1;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_ce", 32'(ce), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 0);

    @(negedge refclk);
    rst = 1'b0;
    wait_lock(n);
    chk("lock_after_rst", n, 256);
    chk("ready_after_rst", 32'(cfg_ready), 1);

    count_ce(64, c0, c1, f0);
    chk("ce0_rate_default", c0, 32);
    chk("ce1_rate_default", c1, 16);
`ifdef VGA_CLK_EN_GEN_PHASE_ALIGN_EN
    chk("ce0_first_aligned", f0, 2);
`endif

    // Write to a channel that does not exist.
    do_write(3'd5, 16'h1234);
    chk("bad_ch_err_pulse", 32'(cfg_err), 1);
    chk("bad_ch_locked", 32'(locked), 1);
    @(posedge refclk);
    #1;
    chk("bad_ch_err_clear", 32'(cfg_err), 0);
    count_ce(64, c0, c1, f0);
    chk("bad_ch_ce0_rate", c0, 32);
    chk("bad_ch_ce1_rate", c1, 16);

    // Reprogram ch1; locked and ce must drop on the accept edge.
    do_write(3'd1, 16'h0001);
    chk("wr_locked_drop", 32'(locked), 0);
    chk("wr_ce_drop", 32'(ce), 0);
    chk("wr_no_err", 32'(cfg_err), 0);
    wait_lock(n);
    chk("relock_after_wr1", n, 256);

    do_write(3'd0, 16'h5555);
    wait_lock(n);
    chk("relock_after_wr0", n, 256);
    count_ce(65536, c0, c1, f0);
    chk("ce0_5555_full_period", c0, 21845);
    chk("ce1_inc1_full_period", c1, 1);

    do_write(3'd1, 16'h0000);
    wait_lock(n);
    chk("relock_after_inc0", n, 256);
    count_ce(1000, c0, c1, f0);
    chk("ce1_inc0_silent", c1, 0);

    // A write on the edge where SETTLE would complete restarts the full count.
    do_write(3'd1, 16'h0000);
    repeat (255) @(posedge refclk);
    #1;
    chk("pre_complete_unlocked", 32'(locked), 0);
    do_write(3'd1, 16'h0000);
    chk("collide_stays_unlocked", 32'(locked), 0);
    wait_lock(n);
    chk("collide_full_restart", n, 256);

    // A one-cycle reset while LOCKED restores INIT_INC.
    @(negedge refclk);
    rst = 1'b1;
    @(posedge refclk);
    #1;
    chk("midrst_locked", 32'(locked), 0);
    chk("midrst_ce", 32'(ce), 0);
    chk("midrst_ready", 32'(cfg_ready), 0);
    @(negedge refclk);
    rst = 1'b0;
    wait_lock(n);
    chk("lock_after_midrst", n, 256);
    count_ce(64, c0, c1, f0);
    chk("midrst_ce0_rate", c0, 32);
    chk("midrst_ce1_rate", c1, 16);
`ifdef VGA_CLK_EN_GEN_PHASE_ALIGN_EN
    chk("midrst_ce0_first_aligned", f0, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
